lsu_stb_cnt: RTL
================

LSU_STB_CNT -- requirements
Module: lsu_stb_cnt

Interface
REQ-001 Parameter STB_DEPTH, default 8: per-thread store buffer capacity; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_l  input  1  reset, asynchronous and active-low.
REQ-004 stb_wr_vld  input  1  a store enters the store buffer of thread stb_wr_tid this cycle.
REQ-005 stb_wr_tid  input  2  thread ID for stb_wr_vld.
REQ-006 stb_rd_vld  input  1  a store retires from the store buffer of thread stb_rd_tid this cycle (L2 ack).
REQ-007 stb_rd_tid  input  2  thread ID for stb_rd_vld.
REQ-008 stb_ctl_reset0..3  input  1 each  per-thread synchronous store buffer flush.
REQ-009 lsu_ifu_stbcnt0..3  output  4 each  registered per-thread occupancy count.
REQ-010 stb_full  output  4  bit t = (count t == STB_DEPTH).
REQ-011 stb_empty  output  4  bit t = (count t == 0).
REQ-012 stb_afull  output  4  bit t = (count t >= STB_DEPTH-1).
REQ-013 stb_ovfl_err  output  4  sticky per-thread overflow-attempt flag.
REQ-014 stb_udfl_err  output  4  sticky per-thread underflow-attempt flag.

Function
REQ-015 Per thread t, a net delta is computed: +1 if stb_wr_vld and stb_wr_tid==t, -1 if stb_rd_vld and stb_rd_tid==t, sum applied.
REQ-016 The count updates one cycle after the event: a write in cycle N is visible on lsu_ifu_stbcnt in cycle N+1.
REQ-017 Write and read to the same thread in the same cycle leave the count unchanged, including at 0 and at STB_DEPTH, and raise no error.
REQ-018 Write and read to different threads in the same cycle update both threads independently.
REQ-019 A write-only to a thread at STB_DEPTH holds the count at STB_DEPTH (saturate); the count never exceeds STB_DEPTH.
REQ-020 A read-only to a thread at 0 holds the count at 0; the count never wraps to 15.
REQ-021 stb_ctl_reset t clears count t to 0 on the next edge, overriding any simultaneous write or read to t.
REQ-022 stb_full, stb_empty and stb_afull are combinational decodes of the registered counts (no extra latency).
REQ-023 Per-thread state machine, states IDLE (count 0), ACTIVE (0 < count < STB_DEPTH), FULL (count == STB_DEPTH), FLUSH (cycle after stb_ctl_reset t); FLUSH returns to IDLE on the next cycle unless the flush is still asserted; state is derived from the next-count value and must match the decode outputs.
REQ-024 While a thread is in FLUSH, writes and reads to that thread are ignored and raise no error.

Reset
REQ-025 On rst_l low, asynchronously: all counts 0, all states IDLE, stb_empty 4'hF, stb_full 0, stb_afull 0 (4'hF if STB_DEPTH==1), stb_ovfl_err 0, stb_udfl_err 0.
REQ-026 Reset asserted mid-operation discards all in-flight deltas; the first post-reset edge with rst_l high applies only that cycle's events.
REQ-027 Sticky error flags clear only on rst_l; stb_ctl_reset does not clear them.

Configuration
REQ-028 Macro LSU_STB_CNT_ERR_CHK_EN: when defined, REQ-019/REQ-020 conditions set stb_ovfl_err[t] / stb_udfl_err[t] on the following edge, and a $display reporting time, thread and condition is issued.
REQ-029 When LSU_STB_CNT_ERR_CHK_EN is undefined, stb_ovfl_err and stb_udfl_err are tied to 0 and no error logic is built; the saturation behaviour is unchanged.

Verification
REQ-030 Reset, then 8 writes to tid 2 on consecutive cycles -> lsu_ifu_stbcnt2 steps 1..8, stb_full[2]=1 at cycle 9, stb_afull[2]=1 from count 7.
REQ-031 Thread 0 at 8, write-only to tid 0 -> count stays 8, stb_ovfl_err[0]=1 next cycle (macro on) or 0 (macro off).
REQ-032 Thread 1 at 0, write+read both tid 1 same cycle -> count 0, no error; read-only tid 1 -> count 0, stb_udfl_err[1]=1 (macro on).
REQ-033 Thread 3 at 5, stb_ctl_reset3 with simultaneous write tid 3 -> count 0 next cycle, FLUSH one cycle, write next cycle -> count 1.
REQ-034 Write tid 0 and read tid 3 (count 4) same cycle -> counts 1 and 3; then rst_l low mid-cycle -> all counts 0 immediately, stb_empty=4'hF, error flags 0.
REQ-035 Random writes/reads/flushes over 10k cycles -> every lsu_ifu_stbcnt stays <= STB_DEPTH and matches a reference scoreboard each cycle.

Source files
------------

// File: rtl/lsu_stb_cnt.sv
// Per-thread (4) store buffer occupancy counters with full/empty/afull decode; optional sticky errors via LSU_STB_CNT_ERR_CHK_EN.
// Latency: counts are registered, one cycle after the write/read/flush; flag decodes are combinational from the counts.
// Backpressure: none; writes at STB_DEPTH and reads at 0 saturate, and flush overrides a same-cycle write or read.
module lsu_stb_cnt #(
    parameter int STB_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       stb_wr_vld,
    input  logic [1:0] stb_wr_tid,
    input  logic       stb_rd_vld,
    input  logic [1:0] stb_rd_tid,
    input  logic       stb_ctl_reset0,
    input  logic       stb_ctl_reset1,
    input  logic       stb_ctl_reset2,
    input  logic       stb_ctl_reset3,
    output logic [3:0] lsu_ifu_stbcnt0,
    output logic [3:0] lsu_ifu_stbcnt1,
    output logic [3:0] lsu_ifu_stbcnt2,
    output logic [3:0] lsu_ifu_stbcnt3,
    output logic [3:0] stb_full,
    output logic [3:0] stb_empty,
    output logic [3:0] stb_afull,
    output logic [3:0] stb_ovfl_err,
    output logic [3:0] stb_udfl_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FULL, ST_FLUSH} state_t;

    localparam logic [3:0] DEPTH = 4'(STB_DEPTH);

    logic [3:0] cnt_q [4];
    logic [3:0] cnt_d [4];
    state_t     state_q [4];
    state_t     state_d [4];
    logic [3:0] flush;
    logic [3:0] wr_hit;
    logic [3:0] rd_hit;
    logic [3:0] live;

    assign flush = {stb_ctl_reset3, stb_ctl_reset2, stb_ctl_reset1, stb_ctl_reset0};

    // A thread only reacts to traffic when it is neither flushing now nor in its post-flush cycle.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        live   = '0;
        for (int t = 0; t < 4; t++) begin
            wr_hit[t] = stb_wr_vld && (stb_wr_tid == 2'(t));
            rd_hit[t] = stb_rd_vld && (stb_rd_tid == 2'(t));
            live[t]   = !flush[t] && (state_q[t] != ST_FLUSH);
        end
    end

    always_comb begin
        for (int t = 0; t < 4; t++) begin
            cnt_d[t]   = cnt_q[t];
            state_d[t] = ST_IDLE;
            if (flush[t]) begin
                cnt_d[t] = 4'd0;
            end else if (live[t]) begin
                if (wr_hit[t] && !rd_hit[t] && (cnt_q[t] != DEPTH)) begin
                    cnt_d[t] = cnt_q[t] + 4'd1;
                end else if (rd_hit[t] && !wr_hit[t] && (cnt_q[t] != 4'd0)) begin
                    cnt_d[t] = cnt_q[t] - 4'd1;
                end
            end
            if (flush[t]) begin
                state_d[t] = ST_FLUSH;
            end else if (cnt_d[t] == 4'd0) begin
                state_d[t] = ST_IDLE;
            end else if (cnt_d[t] == DEPTH) begin
                state_d[t] = ST_FULL;
            end else begin
                state_d[t] = ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int t = 0; t < 4; t++) begin
                cnt_q[t]   <= 4'd0;
                state_q[t] <= ST_IDLE;
            end
        end else begin
            for (int t = 0; t < 4; t++) begin
                cnt_q[t]   <= cnt_d[t];
                state_q[t] <= state_d[t];
            end
        end
    end

    assign lsu_ifu_stbcnt0 = cnt_q[0];
    assign lsu_ifu_stbcnt1 = cnt_q[1];
    assign lsu_ifu_stbcnt2 = cnt_q[2];
    assign lsu_ifu_stbcnt3 = cnt_q[3];

    always_comb begin
        stb_full  = '0;
        stb_empty = '0;
        stb_afull = '0;
        for (int t = 0; t < 4; t++) begin
            stb_full[t]  = (cnt_q[t] == DEPTH);
            stb_empty[t] = (cnt_q[t] == 4'd0);
            stb_afull[t] = (cnt_q[t] >= (DEPTH - 4'd1));
        end
    end

`ifdef LSU_STB_CNT_ERR_CHK_EN
    logic [3:0] ovfl_evt;
    logic [3:0] udfl_evt;
    logic [3:0] ovfl_q;
    logic [3:0] udfl_q;

    always_comb begin
        ovfl_evt = '0;
        udfl_evt = '0;
        for (int t = 0; t < 4; t++) begin
            ovfl_evt[t] = live[t] && wr_hit[t] && !rd_hit[t] && (cnt_q[t] == DEPTH);
            udfl_evt[t] = live[t] && rd_hit[t] && !wr_hit[t] && (cnt_q[t] == 4'd0);
        end
    end

    // Sticky until rst_l; a per-thread flush deliberately leaves them set.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ovfl_q <= '0;
            udfl_q <= '0;
        end else begin
            ovfl_q <= ovfl_q | ovfl_evt;
            udfl_q <= udfl_q | udfl_evt;
            for (int t = 0; t < 4; t++) begin
                if (ovfl_evt[t])
                    $display("%0t lsu_stb_cnt: thread %0d store buffer overflow attempt", $time, t);
                if (udfl_evt[t])
                    $display("%0t lsu_stb_cnt: thread %0d store buffer underflow attempt", $time, t);
            end
        end
    end

    assign stb_ovfl_err = ovfl_q;
    assign stb_udfl_err = udfl_q;
`else
    assign stb_ovfl_err = '0;
    assign stb_udfl_err = '0;
`endif

endmodule
